// File: rtl/fir_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_pkg: shared FSM state type and width helper for fir_filter_mac |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full product width plus enough guard bits to sum TAPS products
    function automatic int acc_width(input int m, input int n, input int taps);
        return 2 * (m + n) + $clog2(taps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_mac: registered signed multiply-accumulate, clear has priority |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module fir_mac #(
    parameter int W     = 8,
    parameter int ACC_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    output logic signed [ACC_W-1:0] acc
);

    localparam int G = ACC_W - 2 * W;

    logic signed [2*W-1:0] w_prod;

    assign w_prod = a * b;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{G{w_prod[2*W-1]}}, w_prod};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_filter_mac.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fir_filter_mac: time-multiplexed FIR, one shared MAC, loadable taps |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module fir_filter_mac
    import fir_pkg::*;
#(
    parameter  int M     = 4,
    parameter  int N     = 4,
    parameter  int TAPS  = 5,
    localparam int W     = M + N,
    localparam int ACC_W = acc_width(M, N, TAPS),
    localparam int AW    = $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] y,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic signed [W-1:0]     coef_data,
    output logic                    busy
);

    state_t              r_state;
    logic [AW-1:0]       r_k;
    logic signed [W-1:0] r_xd [TAPS];
    logic signed [W-1:0] r_h  [TAPS];

    logic w_clr;
    logic w_en;
    logic w_coef_ok;

    assign w_clr     = (r_state == IDLE) && in_valid;
    assign w_en      = (r_state == MAC);
    assign w_coef_ok = coef_we && (int'(coef_addr) < TAPS);

    // The accumulator stays frozen outside MAC, so it doubles as the held output
    fir_mac #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_en),
        .a   (r_xd[r_k]),
        .b   (r_h[r_k]),
        .acc (y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            r_k       <= '0;
            for (int i = 0; i < TAPS; i++) begin
                r_xd[i] <= '0;
                r_h[i]  <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_coef_ok) begin
                        r_h[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            r_xd[i] <= r_xd[i-1];
                        end
                        r_xd[0]  <= x;
                        r_k      <= '0;
                        r_state  <= MAC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MAC: begin
                    if (r_k == AW'(TAPS - 1)) begin
                        r_k       <= '0;
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        r_k <= r_k + AW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_mac.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fir_filter_mac: directed vectors with a queued-expectation monitor |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module tb_fir_filter_mac;

    localparam int W     = 8;
    localparam int ACC_W = 19;
    localparam int AW    = 3;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic             coef_we   = 1'b0;
    logic [W-1:0]     x         = '0;
    logic [W-1:0]     coef_data = '0;
    logic [AW-1:0]    coef_addr = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [ACC_W-1:0] y;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [ACC_W-1:0] exp_q [$];
    logic [ACC_W-1:0] mon_exp;

    fir_filter_mac #(.M(4), .N(4), .TAPS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Every accepted handshake must match the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got y=%h, expected no output", y);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("y", 32'(y), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) fail_now("idle_timeout");
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [W-1:0] d);
        wait_idle();
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic load_h(input logic [W-1:0] h0, h1, h2, h3, h4);
        write_coef(3'd0, h0); write_coef(3'd1, h1); write_coef(3'd2, h2);
        write_coef(3'd3, h3); write_coef(3'd4, h4);
    endtask

    task automatic send(input logic [W-1:0] s, input logic [ACC_W-1:0] e, input bit push,
                        input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
        wait_idle();
        in_valid = 1'b1; x = s;
        coef_we = we; coef_addr = a; coef_data = d;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0; coef_we = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    task automatic impulse_run();
        load_h(8'h30, 8'h10, 8'h08, 8'h10, 8'h30);
        send(8'h10, 19'h00300, 1, 0, 0, 0);
        send(8'h00, 19'h00100, 1, 0, 0, 0);
        send(8'h00, 19'h00080, 1, 0, 0, 0);
        send(8'h00, 19'h00100, 1, 0, 0, 0);
        send(8'h00, 19'h00300, 1, 0, 0, 0);
        drain();
    endtask

    initial begin
        int t;
        reset_dut();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_y", 32'(y), 0);

        impulse_run();

        // Oldest impulse sample falls off the end, leaving only x*h0
        send(8'h10, 19'h00300, 1, 0, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("lat_in_ready", 32'(in_ready), 0);
            chk("lat_busy", 32'(busy), 1);
            chk("lat_out_valid", 32'(out_valid), (c == 6) ? 1 : 0);
        end
        drain();

        out_ready = 1'b0;
        send(8'h10, 19'h00400, 1, 0, 0, 0);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) fail_now("bp_out_valid_timeout");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp_y", 32'(y), 32'h00400);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            in_valid = (c % 2 == 0);
            x = 8'h7F;
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        send(8'h00, 19'h00180, 1, 0, 0, 0);
        drain();

        reset_dut();
        load_h(8'h30, 8'h10, 8'h08, 8'h10, 8'h30);
        send(8'h10, 19'h00300, 1, 0, 0, 0);
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'h7F;
        @(posedge clk);
        #1 coef_we = 1'b0;
        send(8'h10, 19'h00400, 1, 0, 0, 0);
        write_coef(3'd5, 8'h7F);
        send(8'h10, 19'h00380, 1, 1, 3'd0, 8'h20);
        drain();

        reset_dut();
        load_h(8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        send(8'h80, 19'h04000, 1, 0, 0, 0);
        send(8'h80, 19'h08000, 1, 0, 0, 0);
        send(8'h80, 19'h0C000, 1, 0, 0, 0);
        send(8'h80, 19'h10000, 1, 0, 0, 0);
        send(8'h80, 19'h14000, 1, 0, 0, 0);
        drain();

        reset_dut();
        load_h(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
        send(8'h80, 19'h7C080, 1, 0, 0, 0);
        send(8'h80, 19'h78100, 1, 0, 0, 0);
        send(8'h80, 19'h74180, 1, 0, 0, 0);
        send(8'h80, 19'h70200, 1, 0, 0, 0);
        send(8'h80, 19'h6C280, 1, 0, 0, 0);
        drain();

        reset_dut();
        load_h(8'h30, 8'h10, 8'h08, 8'h10, 8'h30);
        send(8'h7F, 19'h0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_y", 32'(y), 0);
        repeat (10) @(negedge clk);
        chk("midrst_no_output", 32'(out_valid), 0);
        impulse_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
